// File: rtl/i2c_register_access.sv
// Register read/write sequencer feeding an i2c byte-level master: one request in, one response out.
// Define I2C_RETRY_EN to re-launch a transfer (up to RETRY_LIMIT times) after arbitration loss or start error.
module i2c_register_access
`ifdef I2C_RETRY_EN
#(
   parameter int RETRY_LIMIT = 3
)
`endif
(
   input  logic       clk_in,
   input  logic       reset,
   // request channel
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [6:0] req_dev_addr,
   input  logic [7:0] req_reg_addr,
   input  logic [7:0] req_wdata,
   // response channel
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [1:0] rsp_status,
   output logic [7:0] rsp_rdata,
   // master control
   output logic       mode,
   output logic       transfer_start,
   output logic       transfer_continue,
   output logic [7:0] data_tx,
   // master status
   input  logic       transfer_ready,
   input  logic       interrupt,
   input  logic       transaction_complete,
   input  logic       nack,
   input  logic       start_err,
   input  logic       arbitration_err,
   input  logic [7:0] data_rx
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA, S_DRAIN, S_RESP
   } state_t;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_NACK_ADDR = 2'd1,
      ST_NACK_DATA = 2'd2,
      ST_ARB_LOST  = 2'd3
   } status_t;

   state_t     state_q;
   status_t    status_q;
   logic       req_ready_q, rsp_valid_q;
   logic [7:0] rdata_q;
   logic       mode_q, start_q, cont_q;
   logic [7:0] data_tx_q;
   logic       wr_q;
   logic [6:0] dev_q;
   logic [7:0] reg_q, wdata_q;

`ifdef I2C_RETRY_EN
   localparam int CNT_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);
   logic [CNT_W-1:0] retry_cnt_q;
   logic             retry_q;
`endif

   // interrupt duplicates transaction_complete/error information, so nothing consumes it
   logic unused_interrupt;
   assign unused_interrupt = interrupt;

   // NOTE: state is written with <= only, so every branch below reads the pre-edge value of
   // every register regardless of statement order; later assignments in a branch simply win.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         // NOTE: the latched request (wr_q/dev_q/reg_q/wdata_q) is deliberately not reset;
         // it is always reloaded on accept before any state reads it.
         state_q     <= S_IDLE;
         status_q    <= ST_OK;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 8'h00;
         mode_q      <= 1'b0;
         start_q     <= 1'b0;
         cont_q      <= 1'b0;
         data_tx_q   <= 8'hFF;
`ifdef I2C_RETRY_EN
         retry_cnt_q <= '0;
         retry_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready_q) begin
                  wr_q        <= req_write;
                  dev_q       <= req_dev_addr;
                  reg_q       <= req_reg_addr;
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  rdata_q     <= 8'h00;
                  status_q    <= ST_OK;
                  data_tx_q   <= {req_dev_addr, 1'b0};
                  mode_q      <= 1'b0;
                  cont_q      <= 1'b1;
                  start_q     <= 1'b1;
                  state_q     <= S_ADDR_W;
`ifdef I2C_RETRY_EN
                  retry_cnt_q <= '0;
                  retry_q     <= 1'b0;
`endif
               end
            end

            S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA: begin
               if (start_err || arbitration_err) begin
                  // bus lost to another master: release everything and wait for it to finish
                  start_q  <= 1'b0;
                  cont_q   <= 1'b0;
                  mode_q   <= 1'b0;
                  status_q <= ST_ARB_LOST;
                  state_q  <= S_DRAIN;
`ifdef I2C_RETRY_EN
                  if (retry_cnt_q < CNT_W'(RETRY_LIMIT)) begin
                     retry_cnt_q <= retry_cnt_q + 1'b1;
                     retry_q     <= 1'b1;
                  end
`endif
               end else if (transaction_complete) begin
                  case (state_q)
                     S_ADDR_W: begin
                        start_q <= 1'b0;
                        if (nack) begin
                           cont_q   <= 1'b0;
                           status_q <= ST_NACK_ADDR;
                           state_q  <= S_DRAIN;
                        end else begin
                           data_tx_q <= reg_q;
                           mode_q    <= 1'b0;
                           state_q   <= S_REG;
                           if (wr_q) begin
                              cont_q <= 1'b1;
                           end else begin
                              // read: repeated START after the register byte
                              cont_q  <= 1'b0;
                              start_q <= 1'b1;
                           end
                        end
                     end
                     S_REG: begin
                        if (nack) begin
                           start_q  <= 1'b0;
                           cont_q   <= 1'b0;
                           status_q <= ST_NACK_DATA;
                           state_q  <= S_DRAIN;
                        end else if (wr_q) begin
                           data_tx_q <= wdata_q;
                           cont_q    <= 1'b0;
                           state_q   <= S_WDATA;
                        end else begin
                           data_tx_q <= {dev_q, 1'b1};
                           mode_q    <= 1'b0;
                           cont_q    <= 1'b1;
                           state_q   <= S_ADDR_R;
                        end
                     end
                     S_WDATA: begin
                        status_q <= nack ? ST_NACK_DATA : ST_OK;
                        start_q  <= 1'b0;
                        cont_q   <= 1'b0;
                        state_q  <= S_DRAIN;
                     end
                     S_ADDR_R: begin
                        start_q <= 1'b0;
                        if (nack) begin
                           cont_q   <= 1'b0;
                           status_q <= ST_NACK_ADDR;
                           state_q  <= S_DRAIN;
                        end else begin
                           // single-byte read: master NACKs it, then issues STOP
                           mode_q    <= 1'b1;
                           cont_q    <= 1'b0;
                           data_tx_q <= 8'hFF;
                           state_q   <= S_RDATA;
                        end
                     end
                     default: begin
                        rdata_q  <= data_rx;
                        status_q <= ST_OK;
                        mode_q   <= 1'b0;
                        start_q  <= 1'b0;
                        cont_q   <= 1'b0;
                        state_q  <= S_DRAIN;
                     end
                  endcase
               end
            end

            S_DRAIN: begin
               start_q <= 1'b0;
               cont_q  <= 1'b0;
               mode_q  <= 1'b0;
               if (transfer_ready) begin
`ifdef I2C_RETRY_EN
                  if (retry_q) begin
                     retry_q   <= 1'b0;
                     status_q  <= ST_OK;
                     data_tx_q <= {dev_q, 1'b0};
                     cont_q    <= 1'b1;
                     start_q   <= 1'b1;
                     state_q   <= S_ADDR_W;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end
`else
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
`endif
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready         = req_ready_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_status        = status_q;
   assign rsp_rdata         = rdata_q;
   assign mode              = mode_q;
   assign transfer_start    = start_q;
   assign transfer_continue = cont_q;
   assign data_tx           = data_tx_q;

endmodule

// File: tb/tb_i2c_register_access.sv
// Directed bench for i2c_register_access: the bench plays the i2c master byte by byte.
// Build with +define+I2C_RETRY_EN to also exercise the arbitration-retry sequence.
module tb_i2c_register_access;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_write;
   logic [6:0] req_dev_addr;
   logic [7:0] req_reg_addr, req_wdata;
   logic       rsp_valid, rsp_ready;
   logic [1:0] rsp_status;
   logic [7:0] rsp_rdata;
   logic       mode, transfer_start, transfer_continue;
   logic [7:0] data_tx;
   logic       transfer_ready, interrupt, transaction_complete, nack, start_err, arbitration_err;
   logic [7:0] data_rx;

   int errors = 0;
   int checks = 0;
   int starts_seen = 0;
   logic start_prev = 1'b0;

   always #5 clk_in = ~clk_in;

   i2c_register_access dut (
      .clk_in               (clk_in),
      .reset                (reset),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_write            (req_write),
      .req_dev_addr         (req_dev_addr),
      .req_reg_addr         (req_reg_addr),
      .req_wdata            (req_wdata),
      .rsp_valid            (rsp_valid),
      .rsp_ready            (rsp_ready),
      .rsp_status           (rsp_status),
      .rsp_rdata            (rsp_rdata),
      .mode                 (mode),
      .transfer_start       (transfer_start),
      .transfer_continue    (transfer_continue),
      .data_tx              (data_tx),
      .transfer_ready       (transfer_ready),
      .interrupt            (interrupt),
      .transaction_complete (transaction_complete),
      .nack                 (nack),
      .start_err            (start_err),
      .arbitration_err      (arbitration_err),
      .data_rx              (data_rx)
   );

   // counts START requests (rising edges of transfer_start)
   always @(negedge clk_in) begin
      if (transfer_start && !start_prev) starts_seen++;
      start_prev = transfer_start;
   end

   typedef struct {
      string      name;
      logic       wr;
      logic [6:0] dev;
      logic [7:0] ra;
      logic [7:0] wd;
      logic [7:0] rx;
      int         nack_at;
      int         err_at;
      logic [1:0] err_kind;    // {start_err, arbitration_err}
      int         hold;
      logic [1:0] exp_status;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   function automatic logic [31:0] ctrl();
      return 32'({transfer_start, transfer_continue, mode, data_tx});
   endfunction

   task automatic pulse(input logic nk, input logic [1:0] er, input logic [7:0] rx);
      repeat (2) tick();
      transaction_complete = 1'b1;
      nack            = nk;
      start_err       = er[1];
      arbitration_err = er[0];
      data_rx         = rx;
      tick();
      transaction_complete = 1'b0;
      nack            = 1'b0;
      start_err       = 1'b0;
      arbitration_err = 1'b0;
   endtask

   task automatic launch(input logic wr, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd);
      req_valid    = 1'b1;
      req_write    = wr;
      req_dev_addr = dev;
      req_reg_addr = ra;
      req_wdata    = wd;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      tick();
      req_valid      = 1'b0;
      transfer_ready = 1'b0;
      check("req_ready_busy", 32'(req_ready), 32'd0);
   endtask

   task automatic finish_rsp(input string name, input logic [1:0] st, input logic [7:0] rd,
                             input int hold);
      check({name, "_released"}, 32'({transfer_start, transfer_continue, mode}), 32'd0);
      tick();
      check({name, "_drain_wait"}, 32'(rsp_valid), 32'd0);
      transfer_ready = 1'b1;
      tick();
      check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_status"}, 32'(rsp_status), 32'(st));
      check({name, "_rdata"}, 32'(rsp_rdata), 32'(rd));
      for (int h = 0; h < hold; h++) begin
         tick();
         check({name, "_hold"}, 32'({rsp_valid, req_ready, rsp_status, rsp_rdata}),
               32'({1'b1, 1'b0, st, rd}));
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({name, "_done"}, 32'({rsp_valid, req_ready}), 32'b01);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t        v;
      logic [31:0] exp_ctrl [4];
      int          nbytes;
      int          s0;
      logic        nk;
      logic [1:0]  er;

      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0;
      transfer_ready = 1'b1; interrupt = 1'b0; transaction_complete = 1'b0;
      nack = 1'b0; start_err = 1'b0; arbitration_err = 1'b0; data_rx = 8'h00;

      //        name          wr  dev    reg    wdata  rx     nack err kind  hold st    rdata
      vecs.push_back('{"wr_ok",      1'b1, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, 2'b00, 0, 2'd0, 8'h00});
      vecs.push_back('{"rd_ok",      1'b0, 7'h50, 8'h22, 8'h00, 8'h3C, -1, -1, 2'b00, 0, 2'd0, 8'h3C});
      vecs.push_back('{"wr_noslave", 1'b1, 7'h51, 8'h10, 8'h5A, 8'h00,  0, -1, 2'b00, 0, 2'd1, 8'h00});
      vecs.push_back('{"wr_nack_reg",1'b1, 7'h50, 8'h10, 8'hA5, 8'h00,  1, -1, 2'b00, 0, 2'd2, 8'h00});
      vecs.push_back('{"wr_nack_dat",1'b1, 7'h50, 8'h11, 8'h00, 8'h00,  2, -1, 2'b00, 0, 2'd2, 8'h00});
      vecs.push_back('{"rd_nack_adr",1'b0, 7'h50, 8'h22, 8'h00, 8'h00,  2, -1, 2'b00, 0, 2'd1, 8'h00});
      vecs.push_back('{"rd_hold",    1'b0, 7'h3A, 8'h05, 8'h00, 8'h81, -1, -1, 2'b00, 4, 2'd0, 8'h81});
      vecs.push_back('{"wr_edge",    1'b1, 7'h7F, 8'hFF, 8'h00, 8'h00, -1, -1, 2'b00, 0, 2'd0, 8'h00});
`ifndef I2C_RETRY_EN
      vecs.push_back('{"wr_arb_reg", 1'b1, 7'h50, 8'h10, 8'hA5, 8'h00, -1,  1, 2'b01, 0, 2'd3, 8'h00});
      vecs.push_back('{"rd_serr_dat",1'b0, 7'h50, 8'h22, 8'h00, 8'h77, -1,  3, 2'b10, 0, 2'd3, 8'h00});
      vecs.push_back('{"rd_arb_adr", 1'b0, 7'h20, 8'h01, 8'h00, 8'h00, -1,  0, 2'b01, 0, 2'd3, 8'h00});
`endif

      // reset state
      repeat (3) tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp", 32'({rsp_valid, rsp_status, rsp_rdata}), 32'd0);
      check("rst_master", ctrl(), 32'({3'b000, 8'hFF}));
      reset = 1'b0;
      tick();

      // reset while the read data byte is in flight
      launch(1'b0, 7'h50, 8'h22, 8'h00);
      repeat (3) pulse(1'b0, 2'b00, 8'h00);
      check("pre_rst_rdata_byte", ctrl(), 32'({3'b001, 8'hFF}));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      transfer_ready = 1'b1;
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_master", ctrl(), 32'({3'b000, 8'hFF}));
      tick();

      foreach (vecs[i]) begin
         v = vecs[i];
         if (v.wr) begin
            nbytes = 3;
            exp_ctrl[0] = 32'({3'b110, v.dev, 1'b0});
            exp_ctrl[1] = 32'({3'b010, v.ra});
            exp_ctrl[2] = 32'({3'b000, v.wd});
            exp_ctrl[3] = 32'd0;
         end else begin
            nbytes = 4;
            exp_ctrl[0] = 32'({3'b110, v.dev, 1'b0});
            exp_ctrl[1] = 32'({3'b100, v.ra});
            exp_ctrl[2] = 32'({3'b110, v.dev, 1'b1});
            exp_ctrl[3] = 32'({3'b001, 8'hFF});
         end
         s0 = starts_seen;
         launch(v.wr, v.dev, v.ra, v.wd);
         for (int b = 0; b < nbytes; b++) begin
            check($sformatf("%s_byte%0d", v.name, b), ctrl(), exp_ctrl[b]);
            nk = (b == v.nack_at);
            er = (b == v.err_at) ? v.err_kind : 2'b00;
            pulse(nk, er, v.rx);
            if (nk || er != 2'b00) break;
         end
         finish_rsp(v.name, v.exp_status, v.exp_rdata, v.hold);
         check({v.name, "_starts"}, 32'(starts_seen - s0), 32'd1);
         tick();
      end

`ifdef I2C_RETRY_EN
      // two arbitration losses on the register byte, then a clean bus
      s0 = starts_seen;
      launch(1'b1, 7'h50, 8'h10, 8'hA5);
      for (int a = 0; a < 3; a++) begin
         check("retry_byte0", ctrl(), 32'({3'b110, 8'hA0}));
         pulse(1'b0, 2'b00, 8'h00);
         check("retry_byte1", ctrl(), 32'({3'b010, 8'h10}));
         if (a < 2) begin
            pulse(1'b0, 2'b01, 8'h00);
            check("retry_released", 32'({transfer_start, transfer_continue, mode}), 32'd0);
            check("retry_no_rsp", 32'({rsp_valid, req_ready}), 32'd0);
            transfer_ready = 1'b1;
            tick();
            transfer_ready = 1'b0;
            check("retry_req_ready", 32'(req_ready), 32'd0);
         end
      end
      pulse(1'b0, 2'b00, 8'h00);
      check("retry_byte2", ctrl(), 32'({3'b000, 8'hA5}));
      pulse(1'b0, 2'b00, 8'h00);
      finish_rsp("retry", 2'd0, 8'h00, 0);
      check("retry_starts", 32'(starts_seen - s0), 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
